// File: rtl/cmult_stream.sv
// Pipelined complex multiplier p = a*b or a*conj(b) with valid/ready flow control,
// scale/saturate output stage and sideband tag; `define CMULT_ROUND_EN for round-half-up scaling.
module cmult_stream #(
    parameter int AWIDTH = 18,
    parameter int BWIDTH = 18,
    parameter int OWIDTH = AWIDTH + BWIDTH + 1,
    parameter int SHIFT  = 0,
    parameter int TWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [AWIDTH-1:0] ar,
    input  logic signed [AWIDTH-1:0] ai,
    input  logic signed [BWIDTH-1:0] br,
    input  logic signed [BWIDTH-1:0] bi,
    input  logic                     conj_b,
    input  logic [TWIDTH-1:0]        tag_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OWIDTH-1:0] pr,
    output logic signed [OWIDTH-1:0] pi,
    output logic [TWIDTH-1:0]        tag_out,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int W  = AWIDTH + BWIDTH + 1;
    localparam int CW = (OWIDTH > W + 1) ? OWIDTH : W + 1;
    localparam logic signed [CW-1:0] SMAX = {{(CW - OWIDTH + 1){1'b0}}, {(OWIDTH - 1){1'b1}}};
    localparam logic signed [CW-1:0] SMIN = ~SMAX;

    logic adv;
    logic [5:1] vld;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1: operand capture, conjugation folded into a widened bi
    logic signed [AWIDTH-1:0] s1_ar, s1_ai;
    logic signed [BWIDTH-1:0] s1_br;
    logic signed [BWIDTH:0]   s1_bi;
    logic signed [BWIDTH:0]   bi_ext;

    // Stage 2: pre-adders feeding the three shared-term products
    logic signed [AWIDTH-1:0] s2_ar, s2_ai;
    logic signed [BWIDTH-1:0] s2_br;
    logic signed [AWIDTH:0]   s2_sa;
    logic signed [BWIDTH+1:0] s2_db, s2_sb;

    // Stage 3/4/5: products, recombination, scaling
    logic signed [W-1:0] s3_k1, s3_k2, s3_k3;
    logic signed [W-1:0] s4_pr, s4_pi;
    logic signed [W:0]   s5_sr, s5_si;
    logic signed [W:0]   sr_d, si_d;

    logic [TWIDTH-1:0] tag_q [1:5];

    assign bi_ext = (BWIDTH + 1)'(bi);

`ifdef CMULT_ROUND_EN
    localparam logic signed [W:0] RND =
        (SHIFT > 0) ? ((W + 1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    assign sr_d = ((W + 1)'(s4_pr) + RND) >>> SHIFT;
    assign si_d = ((W + 1)'(s4_pi) + RND) >>> SHIFT;
`else
    assign sr_d = (W + 1)'(s4_pr) >>> SHIFT;
    assign si_d = (W + 1)'(s4_pi) >>> SHIFT;
`endif

    // Returns {clamped, value}
    function automatic logic [OWIDTH:0] saturate(input logic signed [W:0] s);
        logic signed [CW-1:0] x;
        x = CW'(s);
        if (x > SMAX)      return {1'b1, SMAX[OWIDTH-1:0]};
        else if (x < SMIN) return {1'b1, SMIN[OWIDTH-1:0]};
        else               return {1'b0, x[OWIDTH-1:0]};
    endfunction

    logic [OWIDTH:0] sat_r, sat_i;

    always_comb begin
        sat_r = saturate(s5_sr);
        sat_i = saturate(s5_si);
    end

    // NOTE: datapath and tag registers carry no reset; only valid bits and outputs need a defined value.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_ar    <= ar;
            s1_ai    <= ai;
            s1_br    <= br;
            s1_bi    <= conj_b ? -bi_ext : bi_ext;
            s2_ar    <= s1_ar;
            s2_ai    <= s1_ai;
            s2_br    <= s1_br;
            s2_sa    <= (AWIDTH + 1)'(s1_ar) + (AWIDTH + 1)'(s1_ai);
            s2_db    <= (BWIDTH + 2)'(s1_bi) - (BWIDTH + 2)'(s1_br);
            s2_sb    <= (BWIDTH + 2)'(s1_br) + (BWIDTH + 2)'(s1_bi);
            s3_k1    <= W'(s2_br) * W'(s2_sa);
            s3_k2    <= W'(s2_ar) * W'(s2_db);
            s3_k3    <= W'(s2_ai) * W'(s2_sb);
            s4_pr    <= s3_k1 - s3_k3;
            s4_pi    <= s3_k1 + s3_k2;
            s5_sr    <= sr_d;
            s5_si    <= si_d;
            tag_q[1] <= tag_in;
            for (int i = 2; i <= 5; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld       <= '0;
            out_valid <= 1'b0;
            pr        <= '0;
            pi        <= '0;
            tag_out   <= '0;
            ovf       <= 1'b0;
        end else begin
            if (adv) begin
                vld       <= {vld[4:1], in_valid};
                out_valid <= vld[5];
                if (vld[5]) begin
                    pr      <= sat_r[OWIDTH-1:0];
                    pi      <= sat_i[OWIDTH-1:0];
                    tag_out <= tag_q[5];
                end
            end
            // A new clamp outranks a simultaneous clear
            if (adv && vld[5] && (sat_r[OWIDTH] || sat_i[OWIDTH])) ovf <= 1'b1;
            else if (ovf_clr)                                        ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmult_stream.sv
// Directed and streaming checks for cmult_stream: default, 16-bit saturating and 16-bit shift-by-4 builds.
module tb_cmult_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, out_ready, conj_b, ovf_clr;
    logic signed [17:0] ar, ai, br, bi;
    logic [7:0] tag_in;

    logic in_ready0, out_valid0, ovf0;
    logic signed [36:0] pr0, pi0;
    logic [7:0] tag_out0;
    logic in_ready1, out_valid1, ovf1;
    logic signed [15:0] pr1, pi1;
    logic [7:0] tag_out1;
    logic in_ready2, out_valid2, ovf2;
    logic signed [15:0] pr2, pi2;
    logic [7:0] tag_out2;

    cmult_stream u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .conj_b(conj_b), .tag_in(tag_in),
        .out_valid(out_valid0), .out_ready(out_ready), .pr(pr0), .pi(pi0),
        .tag_out(tag_out0), .ovf(ovf0), .ovf_clr(ovf_clr)
    );

    cmult_stream #(.OWIDTH(16), .SHIFT(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .conj_b(conj_b), .tag_in(tag_in),
        .out_valid(out_valid1), .out_ready(out_ready), .pr(pr1), .pi(pi1),
        .tag_out(tag_out1), .ovf(ovf1), .ovf_clr(ovf_clr)
    );

    cmult_stream #(.OWIDTH(16), .SHIFT(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .conj_b(conj_b), .tag_in(tag_in),
        .out_valid(out_valid2), .out_ready(out_ready), .pr(pr2), .pi(pi2),
        .tag_out(tag_out2), .ovf(ovf2), .ovf_clr(ovf_clr)
    );

`ifdef CMULT_ROUND_EN
    localparam longint EXP_P40 = 3;
`else
    localparam longint EXP_P40 = 2;
`endif

    typedef struct {
        logic signed [63:0] r;
        logic signed [63:0] i;
        logic [7:0]         t;
    } exp_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint a_r, input longint a_i, input longint b_r,
                                   input longint b_i, input logic cj, input logic [7:0] t);
        exp_t e;
        e.r = cj ? (a_r * b_r + a_i * b_i) : (a_r * b_r - a_i * b_i);
        e.i = cj ? (a_i * b_r - a_r * b_i) : (a_r * b_i + a_i * b_r);
        e.t = t;
        return e;
    endfunction

    // Single sample with out_ready=1; returns at the negedge following the sixth edge.
    task automatic apply(input int a_r, input int a_i, input int b_r, input int b_i,
                         input logic cj, input logic [7:0] tg);
        @(negedge clk);
        ar = 18'(a_r); ai = 18'(a_i); br = 18'(b_r); bi = 18'(b_i);
        conj_b = cj; tag_in = tg; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("latency_early", out_valid0, 0);
        @(negedge clk);
        check("latency_valid", out_valid0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    exp_t q[$];
    exp_t e;

    initial begin
        int sent, got, cyc, k;
        logic held, stale;
        logic signed [63:0] hr, hi;
        logic [7:0] ht;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; conj_b = 1'b0; ovf_clr = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0; tag_in = '0;
        do_reset();

        check("rst_out_valid", out_valid0, 0);
        check("rst_pr", pr0, 0);
        check("rst_pi", pi0, 0);
        check("rst_tag", tag_out0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_in_ready", in_ready0, 1);

        apply(3, 4, 5, 6, 1'b0, 8'h5A);
        check("basic_pr", pr0, -9);
        check("basic_pi", pi0, 38);
        check("basic_tag", tag_out0, 8'h5A);
        check("basic_ovf", ovf0, 0);

        apply(3, 4, 5, 6, 1'b1, 8'h3C);
        check("conj_pr", pr0, 39);
        check("conj_pi", pi0, 2);
        check("conj_tag", tag_out0, 8'h3C);

        apply(-131072, -131072, -131072, 131071, 1'b0, 8'h01);
        check("corner_pr", pr0, 64'sd34359607296);
        check("corner_pi", pi0, 64'sd131072);

        apply(-131072, -131072, -131072, -131072, 1'b1, 8'h02);
        check("corner_conj_pr", pr0, 64'sd34359738368);
        check("corner_conj_pi", pi0, 0);
        check("corner_ovf", ovf0, 0);

        // Narrow-output builds
        do_reset();
        apply(5, 0, 8, 0, 1'b0, 8'h10);
        check("shift4_p40", pr2, EXP_P40);
        check("sat16_no_ovf", ovf1, 0);
        apply(-9, 0, 1, 0, 1'b0, 8'h11);
        check("shift4_pm9", pr2, -1);
        apply(300, 0, 300, 0, 1'b0, 8'h12);
        check("sat16_pr", pr1, 32767);
        check("sat16_pi", pi1, 0);
        check("sat16_ovf", ovf1, 1);
        check("shift4_90000", pr2, 5625);

        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        check("ovf_cleared", ovf1, 0);

        ovf_clr = 1'b1;
        apply(300, 0, 300, 0, 1'b0, 8'h13);
        check("ovf_set_wins", ovf1, 1);
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_sticky", ovf1, 1);

        // Random-handshake stream of 20 tagged samples
        do_reset();
        sent = 0; got = 0; cyc = 0; held = 1'b0; hr = '0; hi = '0; ht = '0;
        while (got < 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                check("hold_valid", out_valid0, 1);
                check("hold_pr", pr0, hr);
                check("hold_pi", pi0, hi);
                check("hold_tag", tag_out0, ht);
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 20) && ($urandom_range(0, 1) == 1);
            k = sent;
            ar = 18'(k * 1000 - 7000);
            ai = 18'(123 - k * 50);
            br = 18'(2500 - k * 300);
            bi = 18'(k * 77 - 900);
            conj_b = 1'(k);
            tag_in = 8'(k);
            #1;
            if (out_valid0 && !out_ready) check("stall_in_ready", in_ready0, 0);
            if (in_valid && in_ready0) begin
                q.push_back(model(k * 1000 - 7000, 123 - k * 50, 2500 - k * 300, k * 77 - 900,
                                  1'(k), 8'(k)));
                sent++;
            end
            if (out_valid0 && out_ready) begin
                if (q.size() == 0) begin
                    check("extra_output", out_valid0, 0);
                end else begin
                    e = q.pop_front();
                    check("stream_pr", pr0, e.r);
                    check("stream_pi", pi0, e.i);
                    check("stream_tag", tag_out0, e.t);
                    got++;
                end
            end
            held = out_valid0 && !out_ready;
            hr = pr0; hi = pi0; ht = tag_out0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, 20);

        // Reset with samples in flight
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            ar = 18'(j + 1); ai = 0; br = 2; bi = 0; conj_b = 1'b0; tag_in = 8'(8'hE0 + j);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_pr", pr0, 0);
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid0) stale = 1'b1;
        end
        check("midrst_no_stale", stale, 0);
        apply(3, 4, 5, 6, 1'b0, 8'h77);
        check("post_rst_pr", pr0, -9);
        check("post_rst_pi", pi0, 38);
        check("post_rst_tag", tag_out0, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
